// File: rtl/wb_queue_pkg.sv
// Shared constants for the write-back queue, with fallback values for the Defines.v widths.
// Optional feature macro used by this slice: WB_FORWARD_EN (forward queued results instead of stalling).
`ifndef REG_ADDRESS_LEN
`define REG_ADDRESS_LEN 5
`endif
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif
`ifndef WB_QUEUE_DEPTH
`define WB_QUEUE_DEPTH 4
`endif

package wb_queue_pkg;

    localparam int WB_DEFAULT_DEPTH  = `WB_QUEUE_DEPTH;
    localparam int WB_DEFAULT_ADDR_W = `REG_ADDRESS_LEN;
    localparam int WB_DEFAULT_DATA_W = `REGISTER_LEN;

    // Free slots EXE needs: MEM is older and always takes the first free slot.
    function automatic logic [1:0] exe_slots_needed(input logic mem_valid);
        return mem_valid ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Bundle of producer handshakes, register-file write port and decode hazard lookup for wb_queue.
// With WB_FORWARD_EN defined the bundle also carries the forwarding outputs.
interface wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                     mem_valid;
    logic                     mem_ready;
    logic [ADDR_W-1:0]        mem_dest;
    logic [DATA_W-1:0]        mem_result;
    logic                     exe_valid;
    logic                     exe_ready;
    logic [ADDR_W-1:0]        exe_dest;
    logic [DATA_W-1:0]        exe_result;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_dest;
    logic [DATA_W-1:0]        wb_value;
    logic [ADDR_W-1:0]        src1;
    logic [ADDR_W-1:0]        src2;
    logic                     hazard1;
    logic                     hazard2;
    logic [$clog2(DEPTH):0]   count;
`ifdef WB_FORWARD_EN
    logic                     fwd1_en;
    logic                     fwd2_en;
    logic [DATA_W-1:0]        fwd1_value;
    logic [DATA_W-1:0]        fwd2_value;

    modport slave (
        input  mem_valid, mem_dest, mem_result, exe_valid, exe_dest, exe_result, src1, src2,
        output mem_ready, exe_ready, wb_en, wb_dest, wb_value, hazard1, hazard2, count,
        output fwd1_en, fwd2_en, fwd1_value, fwd2_value
    );
    modport master (
        output mem_valid, mem_dest, mem_result, exe_valid, exe_dest, exe_result, src1, src2,
        input  mem_ready, exe_ready, wb_en, wb_dest, wb_value, hazard1, hazard2, count,
        input  fwd1_en, fwd2_en, fwd1_value, fwd2_value
    );
`else
    modport slave (
        input  mem_valid, mem_dest, mem_result, exe_valid, exe_dest, exe_result, src1, src2,
        output mem_ready, exe_ready, wb_en, wb_dest, wb_value, hazard1, hazard2, count
    );
    modport master (
        output mem_valid, mem_dest, mem_result, exe_valid, exe_dest, exe_result, src1, src2,
        input  mem_ready, exe_ready, wb_en, wb_dest, wb_value, hazard1, hazard2, count
    );
`endif
endinterface

// File: rtl/wb_pending_match.sv
// Compares one decode source against every occupied queue slot; the youngest match wins.
// The value path exists only when WB_FORWARD_EN is defined.
module wb_pending_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = WB_DEFAULT_DEPTH,
    parameter int ADDR_W = WB_DEFAULT_ADDR_W,
    parameter int DATA_W = WB_DEFAULT_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] dests,
`ifdef WB_FORWARD_EN
    input  logic [DEPTH-1:0][DATA_W-1:0] values,
    output logic [DATA_W-1:0]            value,
`endif
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [CNT_W-1:0]             count,
    input  logic [ADDR_W-1:0]            src,
    output logic                         match
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later hit overrides an earlier one.
    always_comb begin
        match = 1'b0;
        idx   = '0;
`ifdef WB_FORWARD_EN
        value = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (dests[idx] == src)) begin
                match = 1'b1;
`ifdef WB_FORWARD_EN
                value = values[idx];
`endif
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back FIFO between the EXE/MEM stages and the register-file write port, plus RAW hazard lookup.
// Define WB_FORWARD_EN to forward the youngest queued value instead of raising hazards.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = `WB_QUEUE_DEPTH,
    parameter int ADDR_W = `REG_ADDRESS_LEN,
    parameter int DATA_W = `REGISTER_LEN
) (
    input logic        clk,
    input logic        rst,
    wb_queue_if.slave  bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [DEPTH-1:0][ENTRY_W-1:0] entries;
    logic [DEPTH-1:0][ADDR_W-1:0]  dests;
    logic [DEPTH-1:0][DATA_W-1:0]  values;
    logic [PTR_W-1:0]              rd_ptr, wr_ptr;
    logic [CNT_W-1:0]              count, free;
    logic                          mem_push, exe_push, pop;
    logic [1:0]                    push_cnt;
    logic                          wb_en;
    logic [ADDR_W-1:0]             wb_dest;
    logic [DATA_W-1:0]             wb_value;
    logic                          match1, match2;

    // Readiness uses the registered count only; a pop in the same cycle does not free a slot early.
    assign free          = CNT_W'(DEPTH) - count;
    assign bus.mem_ready = (free >= CNT_W'(1));
    assign bus.exe_ready = (free >= CNT_W'(exe_slots_needed(bus.mem_valid)));
    assign mem_push      = bus.mem_valid && bus.mem_ready;
    assign exe_push      = bus.exe_valid && bus.exe_ready;
    assign push_cnt      = {1'b0, mem_push} + {1'b0, exe_push};
    assign pop           = (count != '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dests[i]  = entries[i][ENTRY_W-1 -: ADDR_W];
            values[i] = entries[i][DATA_W-1:0];
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (mem_push)
            entries[wr_ptr] <= {bus.mem_dest, bus.mem_result};
        if (exe_push)
            entries[wr_ptr + PTR_W'(mem_push)] <= {bus.exe_dest, bus.exe_result};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wb_en    <= 1'b0;
            wb_dest  <= '0;
            wb_value <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
            wb_en  <= pop;
            if (pop) begin
                wb_dest  <= dests[rd_ptr];
                wb_value <= values[rd_ptr];
            end
        end
    end

    assign bus.wb_en    = wb_en;
    assign bus.wb_dest  = wb_dest;
    assign bus.wb_value = wb_value;
    assign bus.count    = count;

    wb_pending_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
        .dests  (dests),
`ifdef WB_FORWARD_EN
        .values (values),
        .value  (bus.fwd1_value),
`endif
        .rd_ptr (rd_ptr),
        .count  (count),
        .src    (bus.src1),
        .match  (match1)
    );

    wb_pending_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
        .dests  (dests),
`ifdef WB_FORWARD_EN
        .values (values),
        .value  (bus.fwd2_value),
`endif
        .rd_ptr (rd_ptr),
        .count  (count),
        .src    (bus.src2),
        .match  (match2)
    );

`ifdef WB_FORWARD_EN
    assign bus.fwd1_en = match1;
    assign bus.fwd2_en = match2;
    assign bus.hazard1 = 1'b0;
    assign bus.hazard2 = 1'b0;
`else
    assign bus.hazard1 = match1;
    assign bus.hazard2 = match2;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Randomized and directed bench for wb_queue against a queue-based reference model.
// Builds with or without WB_FORWARD_EN.
module tb_wb_queue;
    import wb_queue_pkg::*;

    localparam int DEPTH = `WB_QUEUE_DEPTH;
    localparam int AW    = `REG_ADDRESS_LEN;
    localparam int DW    = `REGISTER_LEN;

    logic clk = 1'b0;
    logic rst;

    wb_queue_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vecCount = 0;
    int errCount = 0;

    // Reference model: in-order list of pending results plus the last value written out.
    logic [AW-1:0] qDest[$];
    logic [DW-1:0] qVal[$];
    logic [AW-1:0] lastDest;
    logic [DW-1:0] lastVal;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelMatch(input logic [AW-1:0] src, output logic hit, output logic [DW-1:0] val);
        hit = 1'b0;
        val = '0;
        foreach (qDest[i]) begin
            if (qDest[i] == src) begin
                hit = 1'b1;
                val = qVal[i];
            end
        end
    endtask

    task automatic checkLookup(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        logic h1, h2;
        logic [DW-1:0] v1, v2;
        modelMatch(s1, h1, v1);
        modelMatch(s2, h2, v2);
`ifdef WB_FORWARD_EN
        checkOutput("hazard1", bus.hazard1, 1'b0);
        checkOutput("hazard2", bus.hazard2, 1'b0);
        checkOutput("fwd1_en", bus.fwd1_en, h1);
        checkOutput("fwd2_en", bus.fwd2_en, h2);
        if (h1) checkOutput("fwd1_value", bus.fwd1_value, v1);
        if (h2) checkOutput("fwd2_value", bus.fwd2_value, v2);
`else
        checkOutput("hazard1", bus.hazard1, h1);
        checkOutput("hazard2", bus.hazard2, h2);
`endif
    endtask

    // One clock: drive inputs, check combinational outputs, clock, then check registered outputs.
    task automatic applyStimulus(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mr,
                                 input logic ev, input logic [AW-1:0] ed, input logic [DW-1:0] er,
                                 input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        logic expMemReady, expExeReady, expWbEn;
        bus.mem_valid  = mv;
        bus.mem_dest   = md;
        bus.mem_result = mr;
        bus.exe_valid  = ev;
        bus.exe_dest   = ed;
        bus.exe_result = er;
        bus.src1       = s1;
        bus.src2       = s2;
        #2;
        expMemReady = (qDest.size() < DEPTH);
        expExeReady = ((qDest.size() + (mv ? 1 : 0)) < DEPTH);
        checkOutput("mem_ready", bus.mem_ready, expMemReady);
        checkOutput("exe_ready", bus.exe_ready, expExeReady);
        checkLookup(s1, s2);
        @(posedge clk);
        #1;
        expWbEn = (qDest.size() > 0);
        if (expWbEn) begin
            lastDest = qDest.pop_front();
            lastVal  = qVal.pop_front();
        end
        if (mv && expMemReady) begin
            qDest.push_back(md);
            qVal.push_back(mr);
        end
        if (ev && expExeReady) begin
            qDest.push_back(ed);
            qVal.push_back(er);
        end
        checkOutput("wb_en", bus.wb_en, expWbEn);
        checkOutput("wb_dest", bus.wb_dest, lastDest);
        checkOutput("wb_value", bus.wb_value, lastVal);
        checkOutput("count", bus.count, qDest.size());
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, AW'(1), AW'(2));
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.mem_valid = 1'b0;
        bus.exe_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qDest.delete();
        qVal.delete();
        lastDest = '0;
        lastVal  = '0;
        checkOutput("rst_count", bus.count, 0);
        checkOutput("rst_wb_en", bus.wb_en, 1'b0);
        checkOutput("rst_wb_dest", bus.wb_dest, 0);
        checkOutput("rst_wb_value", bus.wb_value, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.mem_valid  = 1'b0;
        bus.mem_dest   = '0;
        bus.mem_result = '0;
        bus.exe_valid  = 1'b0;
        bus.exe_dest   = '0;
        bus.exe_result = '0;
        bus.src1       = '0;
        bus.src2       = '0;
        lastDest       = '0;
        lastVal        = '0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Single MEM result through an empty queue, then the write port idles holding its value.
        applyStimulus(1'b1, AW'(3), DW'(32'hAA), 1'b0, '0, '0, AW'(3), '0);
        repeat (2) idleCycle();

        // Same-cycle MEM and EXE: MEM drains first.
        applyStimulus(1'b1, AW'(1), DW'(32'h11), 1'b1, AW'(2), DW'(32'h22), AW'(1), AW'(2));
        repeat (3) idleCycle();

        // Back-to-back double pushes build occupancy up to where EXE is refused.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, AW'(8 + i), DW'(100 + i), 1'b1, AW'(16 + i), DW'(200 + i), AW'(9), AW'(17));
        applyStimulus(1'b0, '0, '0, 1'b1, AW'(20), DW'(300), AW'(20), '0);
        repeat (5) idleCycle();

        // Two queued results for the same register: lookup sees the younger one.
        applyStimulus(1'b1, AW'(5), DW'(32'h50), 1'b1, AW'(5), DW'(32'h55), '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, AW'(5), AW'(6));
        repeat (2) idleCycle();

        // Reset with entries pending discards them; no stale write follows.
        applyStimulus(1'b1, AW'(7), DW'(7), 1'b1, AW'(8), DW'(8), '0, '0);
        applyStimulus(1'b1, AW'(9), DW'(9), 1'b1, AW'(10), DW'(10), '0, '0);
        checkOutput("pre_rst_count", bus.count, 3);
        doReset();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, AW'(9), AW'(10));
        repeat (3) idleCycle();

        // Pointer wrap with a long run of single pushes.
        for (int d = 0; d < 10; d++)
            applyStimulus(1'b1, AW'(d), DW'(10 * d), 1'b0, '0, '0, AW'(d), AW'(0));
        repeat (3) idleCycle();

        // Random traffic on a small register range to provoke frequent hazards.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), DW'($urandom),
                              $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), DW'($urandom),
                              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            end
        end
        repeat (6) idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
